thermal_bit_decoder: RTL and testbench
======================================

THERMAL_BIT_DECODER -- requirements
Module: thermal_bit_decoder

Interface
REQ-001 Parameter CAL_SAMPLES, default 4, number of calibration windows; SHALL be a power of two, 2 to 16.
REQ-002 Parameter MARGIN, default 20'd64, hysteresis half-width around the baseline.
REQ-003 Parameter PREAMBLE, default 8'hA5, sync pattern that precedes every data byte.
REQ-004 One clock; reset is synchronous and active-high (ports clk and reset).
REQ-005 Ports SHALL be, in order:
 clk  input  1  system clock.
 reset  input  1  synchronous active-high reset.
 sample  input  20  per-window ring-oscillator count from the upstream counter stage.
 sample_valid  input  1  one-cycle strobe qualifying sample.
 byte_out  output  8  decoded data byte.
 byte_valid  output  1  byte_out valid; held until accepted.
 byte_ready  input  1  consumer accepts byte when byte_valid and byte_ready are both high.
 leds  output  8  last accepted byte.
 state  output  2  0=CALIB, 1=HUNT, 2=RECV, 3=HOLD.
 err_count  output  8  saturating count of dead-zone aborts and dropped samples.

Function
REQ-006 Only cycles with sample_valid=1 SHALL advance decoding; all other cycles hold state.
REQ-007 CALIB: accumulate CAL_SAMPLES samples in a 24-bit accumulator; on the last one, baseline (20 bits) = accumulator >> log2(CAL_SAMPLES), clear accumulator, go to HUNT.
REQ-008 Thresholds SHALL be computed at 21 bits: hi = baseline + MARGIN; lo = baseline - MARGIN, saturating at 0.
REQ-009 Decision per sample: sample >= hi -> bit 1; sample <= lo -> bit 0; otherwise dead zone.
REQ-010 HUNT: shift decided bits into an 8-bit register, LSB in; 4-bit valid-bit counter saturates at 8.
REQ-011 HUNT dead zone: clear shift register and counter, stay in HUNT; err_count unchanged.
REQ-012 HUNT -> RECV on the edge where the counter reaches or is at 8 and the updated shift register equals PREAMBLE.
REQ-013 RECV: collect exactly 8 bits MSB first; on the 8th, load byte_out, assert byte_valid, go to HOLD, both visible the cycle after the 8th sample_valid.
REQ-014 RECV dead zone: discard partial byte, err_count += 1, go to HUNT with cleared shift register.
REQ-015 HOLD: byte_out and byte_valid stable until the byte_valid&byte_ready edge; on that edge deassert byte_valid, leds <= byte_out, go to HUNT with cleared shift register.
REQ-016 Any sample_valid in HOLD that is not on the handshake edge SHALL be dropped and err_count += 1; a sample on the handshake edge is also dropped, without error.
REQ-017 err_count SHALL saturate at 8'hFF; simultaneous increment sources count once.
REQ-018 byte_ready while byte_valid=0 SHALL have no effect.
REQ-019 Baseline SHALL never update outside CALIB.

Reset
REQ-020 On reset: state=CALIB, accumulator, calibration count, baseline, shift register, bit counter = 0; byte_out=0, byte_valid=0, leds=0, err_count=0.
REQ-021 Reset SHALL override every other event in the same cycle, including handshake and sample_valid, and abort any state mid-operation.

Verification
REQ-022 Calibration: samples 1000,1000,1000,1000 -> state=HUNT, baseline 1000 (hi 1064, lo 936); a 5th strobe is decoded, not accumulated.
REQ-023 Byte receive: after calibration, bits of A5 then 3C (1100=1, 900=0), byte_ready=1 -> byte_valid one cycle after last strobe with byte_out=8'h3C, leds=8'h3C the following cycle, state=HUNT.
REQ-024 Dead-zone abort: preamble, 3 data bits, then sample 1000 -> state=HUNT, err_count=1, no byte_valid; fresh preamble + byte still decodes.
REQ-025 Backpressure: byte decoded with byte_ready=0, two further strobes -> byte_out stable, err_count=2; byte_ready=1 releases, leds updates.
REQ-026 Boundary/saturation: baseline 40 -> lo saturates to 0, sample 0 decodes as 0, sample 104 as 1; 300 forced dead-zone aborts -> err_count=8'hFF.
REQ-027 Reset mid-RECV with simultaneous sample_valid -> next cycle all outputs zero, state=CALIB, sample ignored.

Source files
------------

// File: rtl/thermal_bit_decoder.sv
// Thermal covert-channel bit decoder: calibrates a baseline from
// ring-oscillator counts, hunts a preamble, then receives one byte.
//
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   sample        20-bit per-window oscillator count
//   sample_valid  one-cycle strobe qualifying sample
//   byte_out      decoded data byte
//   byte_valid    byte_out valid; held until accepted
//   byte_ready    consumer accept
//   leds          last accepted byte
//   state         0=CALIB 1=HUNT 2=RECV 3=HOLD
//   err_count     saturating count of aborts and dropped samples
module thermal_bit_decoder #(
  parameter int          CAL_SAMPLES = 4,
  parameter logic [19:0] MARGIN      = 20'd64,
  parameter logic [7:0]  PREAMBLE    = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] sample,
  input  logic        sample_valid,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic [7:0]  leds,
  output logic [1:0]  state,
  output logic [7:0]  err_count
);

  localparam logic [1:0] CALIB = 2'd0;
  localparam logic [1:0] HUNT  = 2'd1;
  localparam logic [1:0] RECV  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam int CW = $clog2(CAL_SAMPLES);

  logic [23:0]   acc;
  logic [23:0]   acc_n;
  logic [CW-1:0] cal_cnt;
  logic          cal_last;
  logic [19:0]   baseline;
  logic [7:0]    sr;
  logic [7:0]    sr_n;
  logic [3:0]    cnt;
  logic [3:0]    cnt_sat;
  logic [20:0]   hi;
  logic [20:0]   lo;
  logic [20:0]   s21;
  logic          is_one;
  logic          is_zero;
  logic          dead;
  logic          hs;
  logic          err_inc;

  // Thresholds at 21 bits so hi never wraps and lo clamps at zero
  always_comb begin
    hi = {1'b0, baseline} + {1'b0, MARGIN};
    lo = '0;
    if (baseline >= MARGIN)
      lo = {1'b0, baseline - MARGIN};
  end

  always_comb begin
    s21      = {1'b0, sample};
    is_one   = s21 >= hi;
    is_zero  = !is_one && (s21 <= lo);
    dead     = !is_one && !is_zero;
    sr_n     = {sr[6:0], is_one};
    cnt_sat  = (cnt >= 4'd8) ? 4'd8 : cnt + 4'd1;
    acc_n    = acc + 24'(sample);
    cal_last = cal_cnt == CW'(CAL_SAMPLES - 1);
    hs       = byte_valid && byte_ready;
  end

  // One increment per cycle at most, even if several causes coincide
  always_comb begin
    err_inc = 1'b0;
    if (sample_valid) begin
      if (state == RECV && dead)
        err_inc = 1'b1;
      if (state == HOLD && !hs)
        err_inc = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CALIB;
      acc        <= '0;
      cal_cnt    <= '0;
      baseline   <= '0;
      sr         <= '0;
      cnt        <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      leds       <= '0;
      err_count  <= '0;
    end else begin
      if (err_inc && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
      unique case (state)
        CALIB: begin
          if (sample_valid) begin
            if (cal_last) begin
              baseline <= 20'(acc_n >> CW);
              acc      <= '0;
              cal_cnt  <= '0;
              state    <= HUNT;
            end else begin
              acc     <= acc_n;
              cal_cnt <= cal_cnt + 1'b1;
            end
          end
        end
        HUNT: begin
          if (sample_valid) begin
            if (dead) begin
              sr  <= '0;
              cnt <= '0;
            end else if (cnt_sat == 4'd8 && sr_n == PREAMBLE) begin
              sr    <= '0;
              cnt   <= '0;
              state <= RECV;
            end else begin
              sr  <= sr_n;
              cnt <= cnt_sat;
            end
          end
        end
        RECV: begin
          if (sample_valid) begin
            if (dead) begin
              sr    <= '0;
              cnt   <= '0;
              state <= HUNT;
            end else if (cnt == 4'd7) begin
              byte_out   <= sr_n;
              byte_valid <= 1'b1;
              sr         <= '0;
              cnt        <= '0;
              state      <= HOLD;
            end else begin
              sr  <= sr_n;
              cnt <= cnt + 4'd1;
            end
          end
        end
        HOLD: begin
          if (hs) begin
            byte_valid <= 1'b0;
            leds       <= byte_out;
            sr         <= '0;
            cnt        <= '0;
            state      <= HUNT;
          end
        end
        default: state <= CALIB;
      endcase
    end
  end

endmodule

// File: tb/tb_thermal_bit_decoder.sv
// Directed bench for thermal_bit_decoder with hand-computed
// expectations and one checking task.
module tb_thermal_bit_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] sample;
  logic        sample_valid;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  leds;
  logic [1:0]  state;
  logic [7:0]  err_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  thermal_bit_decoder dut (
    .clk          (clk),
    .reset        (reset),
    .sample       (sample),
    .sample_valid (sample_valid),
    .byte_out     (byte_out),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .leds         (leds),
    .state        (state),
    .err_count    (err_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [19:0] v);
    sample       = v;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input logic [19:0] one_v,
                           input logic [19:0] zero_v);
    for (int i = 7; i >= 0; i--)
      send(b[i] ? one_v : zero_v);
  endtask

  initial begin
    reset        = 1'b1;
    sample       = '0;
    sample_valid = 1'b0;
    byte_ready   = 1'b0;
    tick();
    tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_bout", 32'(byte_out), 32'd0);
    chk("rst_bval", 32'(byte_valid), 32'd0);
    chk("rst_leds", 32'(leds), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    reset = 1'b0;
    tick();

    // calibration to 1000: hi 1064, lo 936
    for (int i = 0; i < 3; i++) send(20'd1000);
    chk("cal_mid", 32'(state), 32'd0);
    send(20'd1000);
    chk("cal_done", 32'(state), 32'd1);

    // preamble at exact thresholds, then 3C
    byte_ready = 1'b1;
    send_byte(8'hA5, 20'd1064, 20'd936);
    chk("pre_recv", 32'(state), 32'd2);
    send_byte(8'h3C, 20'd1100, 20'd900);
    chk("rx_bval", 32'(byte_valid), 32'd1);
    chk("rx_bout", 32'(byte_out), 32'h3C);
    chk("rx_hold", 32'(state), 32'd3);
    tick();
    chk("rx_leds", 32'(leds), 32'h3C);
    chk("rx_bval0", 32'(byte_valid), 32'd0);
    chk("rx_hunt", 32'(state), 32'd1);

    // dead-zone abort inside RECV
    send_byte(8'hA5, 20'd1100, 20'd900);
    send(20'd1100);
    send(20'd900);
    send(20'd1100);
    send(20'd1000);
    chk("dz_state", 32'(state), 32'd1);
    chk("dz_err", 32'(err_count), 32'd1);
    chk("dz_bval", 32'(byte_valid), 32'd0);
    send_byte(8'hA5, 20'd1100, 20'd900);
    send_byte(8'h5A, 20'd1100, 20'd900);
    chk("dz2_bval", 32'(byte_valid), 32'd1);
    chk("dz2_bout", 32'(byte_out), 32'h5A);
    tick();
    chk("dz2_leds", 32'(leds), 32'h5A);

    // just-inside-margin samples are dead zone
    send(20'd1063);
    chk("hunt_dz_st", 32'(state), 32'd1);
    chk("hunt_dz_err", 32'(err_count), 32'd1);
    send_byte(8'hA5, 20'd1100, 20'd900);
    send(20'd937);
    chk("recv_dz_st", 32'(state), 32'd1);
    chk("recv_dz_err", 32'(err_count), 32'd2);

    // backpressure: two dropped strobes while holding
    byte_ready = 1'b0;
    send_byte(8'hA5, 20'd1100, 20'd900);
    send_byte(8'hC3, 20'd1100, 20'd900);
    chk("bp_bval", 32'(byte_valid), 32'd1);
    send(20'd1100);
    send(20'd900);
    tick();
    chk("bp_bout", 32'(byte_out), 32'hC3);
    chk("bp_bval2", 32'(byte_valid), 32'd1);
    chk("bp_err", 32'(err_count), 32'd4);
    chk("bp_leds", 32'(leds), 32'h5A);
    chk("bp_state", 32'(state), 32'd3);
    // release with a strobe on the handshake edge: no error
    byte_ready = 1'b1;
    send(20'd1100);
    chk("rel_leds", 32'(leds), 32'hC3);
    chk("rel_bval", 32'(byte_valid), 32'd0);
    chk("rel_err", 32'(err_count), 32'd4);
    chk("rel_state", 32'(state), 32'd1);
    tick();
    tick();
    chk("idle_rdy_leds", 32'(leds), 32'hC3);

    // reset mid-RECV with a coincident strobe
    send_byte(8'hA5, 20'd1100, 20'd900);
    send(20'd1100);
    send(20'd900);
    reset = 1'b1;
    send(20'd1100);
    chk("mr_state", 32'(state), 32'd0);
    chk("mr_bout", 32'(byte_out), 32'd0);
    chk("mr_bval", 32'(byte_valid), 32'd0);
    chk("mr_leds", 32'(leds), 32'd0);
    chk("mr_err", 32'(err_count), 32'd0);
    reset = 1'b0;
    tick();

    // baseline 40: lo clamps to 0, hi is 104
    for (int i = 0; i < 4; i++) send(20'd40);
    chk("b40_state", 32'(state), 32'd1);
    send_byte(8'hA5, 20'd104, 20'd0);
    chk("b40_recv", 32'(state), 32'd2);
    send_byte(8'h96, 20'd104, 20'd0);
    chk("b40_bout", 32'(byte_out), 32'h96);
    tick();
    chk("b40_leds", 32'(leds), 32'h96);

    // saturation of err_count
    for (int k = 0; k < 300; k++) begin
      send_byte(8'hA5, 20'd104, 20'd0);
      send(20'd50);
      if (k == 253)
        chk("sat_fe", 32'(err_count), 32'hFE);
    end
    chk("sat_ff", 32'(err_count), 32'hFF);
    chk("sat_state", 32'(state), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
